// File: rtl/fwd_pkg.sv
// Shared types for the forwarding / load-use hazard unit.
// Pure declarations; no timing of its own.
// No flow control here; consumers decide stall behaviour.
package fwd_pkg;

    // Register index field is held at a fixed generous width so the table
    // type does not depend on the top-level ADDR_W parameter.
    localparam int FWD_RD_W     = 16;

    // Default hard-zero register index (never forwarded, never stalls).
    localparam int FWD_ZERO_REG = 31;

    // One in-flight instruction as seen by the hazard logic.
    typedef struct packed {
        logic                valid;
        logic [FWD_RD_W-1:0] rd;
        logic                wen;
        logic                load;
    } fwd_entry_t;

    // A producer at stage k has usable data unless it is a load that has
    // not yet spent LOAD_LAT stages in the pipe.
    function automatic logic fwd_entry_ready(input logic load,
                                             input int   k,
                                             input int   load_lat);
        return !load || (k >= load_lat - 1);
    endfunction

endpackage

// File: rtl/fwd_port_sel.sv
// Per-read-port operand select: youngest matching producer wins.
// Purely combinational, zero cycles from table/inputs to outputs.
// Requests a stall when the youngest producer is a load not yet ready.
module fwd_port_sel
    import fwd_pkg::*;
#(
    parameter int DATA_W   = 64,
    parameter int ADDR_W   = 5,
    parameter int DEPTH    = 2,
    parameter int LOAD_LAT = 2,
    parameter int ZERO_REG = FWD_ZERO_REG
) (
    input  fwd_entry_t [DEPTH-1:0]             ent_i,
    input  logic       [DEPTH-1:0][DATA_W-1:0] stage_data_i,
    input  logic       [ADDR_W-1:0]            rd_addr_i,
    input  logic                               rd_used_i,
    input  logic       [DATA_W-1:0]            rf_data_i,
    input  logic                               iss_valid_i,
    output logic       [DATA_W-1:0]            sel_data_o,
    output logic                               stall_req_o
);

    logic               is_zero;
    logic [FWD_RD_W-1:0] addr_ext;

    assign is_zero  = (rd_addr_i == ADDR_W'(ZERO_REG));
    assign addr_ext = FWD_RD_W'(rd_addr_i);

    // Scan from youngest (k=0) to oldest; the first hit decides the outcome.
    always_comb begin
        logic found;
        found       = 1'b0;
        sel_data_o  = rf_data_i;
        stall_req_o = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            if (!found && !is_zero && ent_i[k].valid && ent_i[k].wen &&
                (ent_i[k].rd == addr_ext)) begin
                found = 1'b1;
                if (fwd_entry_ready(ent_i[k].load, k, LOAD_LAT)) begin
                    sel_data_o = stage_data_i[k];
                end else begin
                    stall_req_o = rd_used_i & iss_valid_i;
                end
            end
        end
    end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding mux + load-use stall generation between decode and execute.
// fwd_data/stall are same-cycle combinational; table and counter update on clk.
// Downstream never stalls; stall only holds decode, flush overrides stall.
module fwd_hazard_unit
    import fwd_pkg::*;
#(
    parameter int DATA_W   = 64,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int DEPTH    = 2,
    parameter int LOAD_LAT = 2,
    parameter int ZERO_REG = FWD_ZERO_REG,
    parameter int CNT_W    = 16
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic [NUM_RD-1:0][ADDR_W-1:0]     rd_addr,
    input  logic [NUM_RD-1:0]                 rd_used,
    input  logic [NUM_RD-1:0][DATA_W-1:0]     rf_data,
    input  logic                              iss_valid,
    input  logic [ADDR_W-1:0]                 iss_rd,
    input  logic                              iss_wen,
    input  logic                              iss_load,
    input  logic                              flush,
    input  logic [DEPTH-1:0][DATA_W-1:0]      stage_data,
    output logic [NUM_RD-1:0][DATA_W-1:0]     fwd_data,
    output logic                              stall,
    output logic [CNT_W-1:0]                  stall_cnt
);

    fwd_entry_t [DEPTH-1:0] ent_q, ent_d;
    logic       [NUM_RD-1:0] stall_req;
    logic       [CNT_W-1:0]  cnt_q, cnt_d;

    // One selector per read port, all looking at the same table.
    for (genvar p = 0; p < NUM_RD; p++) begin : g_port
        fwd_port_sel #(
            .DATA_W   (DATA_W),
            .ADDR_W   (ADDR_W),
            .DEPTH    (DEPTH),
            .LOAD_LAT (LOAD_LAT),
            .ZERO_REG (ZERO_REG)
        ) u_sel (
            .ent_i        (ent_q),
            .stage_data_i (stage_data),
            .rd_addr_i    (rd_addr[p]),
            .rd_used_i    (rd_used[p]),
            .rf_data_i    (rf_data[p]),
            .iss_valid_i  (iss_valid),
            .sel_data_o   (fwd_data[p]),
            .stall_req_o  (stall_req[p])
        );
    end

    // A flushed decode instruction is dead, so it can never cause a stall.
    assign stall     = (|stall_req) & ~flush;
    assign stall_cnt = cnt_q;

    // Table always advances; entry 0 takes the issuing instruction or a bubble.
    always_comb begin
        ent_d = '0;
        for (int k = 1; k < DEPTH; k++) begin
            ent_d[k] = ent_q[k-1];
        end
        if (!stall && !flush) begin
            ent_d[0].valid = iss_valid;
            ent_d[0].rd    = FWD_RD_W'(iss_rd);
            ent_d[0].wen   = iss_wen;
            ent_d[0].load  = iss_load;
        end
    end

    // Stall counter saturates at all-ones instead of wrapping.
    always_comb begin
        cnt_d = cnt_q;
        if (stall && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // State registers; reset empties the table so stall drops immediately.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ent_q <= '0;
            cnt_q <= '0;
        end else begin
            ent_q <= ent_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Self-checking bench: directed scenarios plus random traffic against an
// age-indexed reference of accepted instructions.
module tb_fwd_hazard_unit;

    localparam int DATA_W   = 64;
    localparam int ADDR_W   = 5;
    localparam int NUM_RD   = 2;
    localparam int DEPTH    = 2;
    localparam int LOAD_LAT = 2;
    localparam int ZREG     = 31;

    logic                          clk = 1'b0;
    logic                          reset_n;
    logic [NUM_RD-1:0][ADDR_W-1:0] rd_addr;
    logic [NUM_RD-1:0]             rd_used;
    logic [NUM_RD-1:0][DATA_W-1:0] rf_data;
    logic                          iss_valid;
    logic [ADDR_W-1:0]             iss_rd;
    logic                          iss_wen;
    logic                          iss_load;
    logic                          flush;
    logic [DEPTH-1:0][DATA_W-1:0]  stage_data;
    logic [NUM_RD-1:0][DATA_W-1:0] fwd_data, fwd_data_s;
    logic                          stall, stall_s;
    logic [15:0]                   stall_cnt;
    logic [3:0]                    stall_cnt_s;

    always #5 clk = ~clk;

    fwd_hazard_unit #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD),
                      .DEPTH(DEPTH), .LOAD_LAT(LOAD_LAT), .ZERO_REG(ZREG),
                      .CNT_W(16)) u_dut (
        .clk(clk), .reset_n(reset_n), .rd_addr(rd_addr), .rd_used(rd_used),
        .rf_data(rf_data), .iss_valid(iss_valid), .iss_rd(iss_rd),
        .iss_wen(iss_wen), .iss_load(iss_load), .flush(flush),
        .stage_data(stage_data), .fwd_data(fwd_data), .stall(stall),
        .stall_cnt(stall_cnt));

    fwd_hazard_unit #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD),
                      .DEPTH(DEPTH), .LOAD_LAT(LOAD_LAT), .ZERO_REG(ZREG),
                      .CNT_W(4)) u_dut_sat (
        .clk(clk), .reset_n(reset_n), .rd_addr(rd_addr), .rd_used(rd_used),
        .rf_data(rf_data), .iss_valid(iss_valid), .iss_rd(iss_rd),
        .iss_wen(iss_wen), .iss_load(iss_load), .flush(flush),
        .stage_data(stage_data), .fwd_data(fwd_data_s), .stall(stall_s),
        .stall_cnt(stall_cnt_s));

    // Reference: what was accepted into execute 1..DEPTH cycles ago.
    typedef struct {
        bit valid;
        int rd;
        bit wen;
        bit load;
    } rec_t;

    rec_t            hist [DEPTH];
    int unsigned     m_stalls;
    logic [DATA_W-1:0] exp_fwd [NUM_RD];
    bit              exp_stall;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic longint sat(input int unsigned c, input int w);
        longint mx;
        mx = (longint'(1) << w) - 1;
        return (longint'(c) > mx) ? mx : longint'(c);
    endfunction

    task automatic model_clear();
        for (int k = 0; k < DEPTH; k++) hist[k] = '{0, 0, 0, 0};
        m_stalls = 0;
    endtask

    // A producer that was accepted (k+1) cycles ago has data unless it is a
    // load that has not yet been in flight for LOAD_LAT cycles.
    task automatic model_eval();
        bit need;
        need = 0;
        for (int p = 0; p < NUM_RD; p++) begin
            int a;
            a = int'(rd_addr[p]);
            exp_fwd[p] = rf_data[p];
            if (a != ZREG) begin
                for (int k = 0; k < DEPTH; k++) begin
                    if (hist[k].valid && hist[k].wen && hist[k].rd == a) begin
                        if (hist[k].load && (k + 1) < LOAD_LAT) begin
                            if (rd_used[p] && iss_valid) need = 1;
                        end else begin
                            exp_fwd[p] = stage_data[k];
                        end
                        break;
                    end
                end
            end
        end
        exp_stall = need && !flush;
    endtask

    task automatic model_step();
        if (exp_stall) m_stalls++;
        for (int k = DEPTH - 1; k > 0; k--) hist[k] = hist[k-1];
        if (!exp_stall && !flush)
            hist[0] = '{iss_valid, int'(iss_rd), iss_wen, iss_load};
        else
            hist[0] = '{0, 0, 0, 0};
    endtask

    task automatic settle();
        @(negedge clk);
        model_eval();
        for (int p = 0; p < NUM_RD; p++) begin
            chk($sformatf("fwd%0d", p), fwd_data[p], exp_fwd[p]);
            chk($sformatf("fwd%0d_s", p), fwd_data_s[p], exp_fwd[p]);
        end
        chk("stall", 64'(stall), 64'(exp_stall));
        chk("stall_s", 64'(stall_s), 64'(exp_stall));
        chk("cnt", 64'(stall_cnt), 64'(sat(m_stalls, 16)));
        chk("cnt_s", 64'(stall_cnt_s), 64'(sat(m_stalls, 4)));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic drive(input bit v, input int rd, input bit wen, input bit ld,
                         input bit fl, input int a0, input bit u0,
                         input int a1, input bit u1);
        iss_valid  = v;
        iss_rd     = ADDR_W'(rd);
        iss_wen    = wen;
        iss_load   = ld;
        flush      = fl;
        rd_addr[0] = ADDR_W'(a0);
        rd_used[0] = u0;
        rd_addr[1] = ADDR_W'(a1);
        rd_used[1] = u1;
        for (int p = 0; p < NUM_RD; p++) rf_data[p] = {$urandom, $urandom};
        for (int k = 0; k < DEPTH; k++) stage_data[k] = {$urandom, $urandom};
    endtask

    // Asynchronous reset pulse in the middle of a clock phase.
    task automatic async_reset();
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        model_clear();
        chk("rst_stall", 64'(stall), 64'd0);
        chk("rst_cnt", 64'(stall_cnt), 64'd0);
        chk("rst_cnt_s", 64'(stall_cnt_s), 64'd0);
        chk("rst_fwd0", fwd_data[0], rf_data[0]);
        chk("rst_fwd1", fwd_data[1], rf_data[1]);
        @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    function automatic int pick_reg();
        int r;
        r = int'($urandom_range(0, 9));
        return (r == 9) ? ZREG : r;
    endfunction

    initial begin
        reset_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        model_clear();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("init_stall", 64'(stall), 64'd0);
        chk("init_cnt", 64'(stall_cnt), 64'd0);
        @(posedge clk);
        #1 reset_n = 1'b1;

        // Reset while a load-use stall is active.
        drive(1, 3, 1, 1, 0, 0, 0, 0, 0); settle(); tick();
        drive(1, 3, 1, 1, 0, 3, 1, 3, 1); settle();
        chk("pre_rst_stall", 64'(stall), 64'd1);
        async_reset();

        // ALU back-to-back.
        drive(1, 5, 1, 0, 0, 0, 0, 1, 0); settle(); tick();
        drive(1, 6, 1, 0, 0, 5, 1, 0, 0);
        stage_data[0] = 64'h1234;
        settle();
        chk("alu_fwd", fwd_data[0], 64'h1234);
        chk("alu_stall", 64'(stall), 64'd0);
        tick();

        // Priority: youngest producer of x7 wins.
        drive(1, 7, 1, 0, 0, 0, 0, 0, 0); settle(); tick();
        drive(1, 7, 1, 0, 0, 0, 0, 0, 0); settle(); tick();
        drive(1, 8, 1, 0, 0, 7, 1, 7, 1);
        stage_data[1] = 64'hAAAA;
        stage_data[0] = 64'hBBBB;
        settle();
        chk("prio_fwd0", fwd_data[0], 64'hBBBB);
        chk("prio_fwd1", fwd_data[1], 64'hBBBB);
        tick();

        // Load-use: one stall cycle then forward from stage 1.
        async_reset();
        drive(1, 2, 1, 1, 0, 0, 0, 0, 0); settle(); tick();
        drive(1, 9, 1, 0, 0, 2, 1, 0, 0); settle();
        chk("lu_stall", 64'(stall), 64'd1);
        tick();
        drive(1, 9, 1, 0, 0, 2, 1, 0, 0);
        stage_data[1] = 64'hDEAD;
        settle();
        chk("lu_stall2", 64'(stall), 64'd0);
        chk("lu_fwd", fwd_data[0], 64'hDEAD);
        chk("lu_cnt", 64'(stall_cnt), 64'd1);
        tick();

        // Zero register and unused port never stall.
        async_reset();
        drive(1, 31, 1, 1, 0, 0, 0, 0, 0); settle(); tick();
        drive(1, 4, 1, 1, 0, 0, 0, 0, 0); settle(); tick();
        drive(1, 10, 1, 0, 0, 31, 1, 4, 0); settle();
        chk("zr_stall", 64'(stall), 64'd0);
        chk("zr_fwd0", fwd_data[0], rf_data[0]);
        chk("zr_fwd1", fwd_data[1], rf_data[1]);
        tick();

        // Flush during a load-use stall: no stall, entry 0 becomes a bubble.
        async_reset();
        drive(1, 3, 1, 1, 0, 0, 0, 0, 0); settle(); tick();
        drive(1, 9, 1, 0, 1, 3, 1, 0, 0); settle();
        chk("fl_stall", 64'(stall), 64'd0);
        tick();
        drive(0, 0, 0, 0, 0, 3, 1, 9, 1); settle();
        chk("fl_fwd_ld", fwd_data[0], stage_data[1]);
        chk("fl_bubble", fwd_data[1], rf_data[1]);
        tick();

        // Saturation: 20 stall cycles in 40.
        async_reset();
        for (int i = 0; i < 40; i++) begin
            drive(1, 6, 1, 1, 0, 6, 1, 0, 0);
            settle();
            tick();
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0); settle();
        chk("sat_cnt16", 64'(stall_cnt), 64'd20);
        chk("sat_cnt4", 64'(stall_cnt_s), 64'd15);
        tick();

        // Random traffic with occasional asynchronous resets.
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 9) != 0, pick_reg(), $urandom_range(0, 3) != 0,
                  $urandom_range(0, 2) == 0, $urandom_range(0, 9) == 0,
                  pick_reg(), $urandom_range(0, 3) != 0,
                  pick_reg(), $urandom_range(0, 3) != 0);
            if ($urandom_range(0, 299) == 0) begin
                async_reset();
            end else begin
                settle();
                tick();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/fwd_hazard_unit.md
# fwd_hazard_unit

Parametrised forwarding and load-use hazard unit for the pipelined CPU, sitting between the decode/register-read stage and the execute stage. It keeps its own in-flight write table (destination, write-enable, load flag per downstream stage), selects forwarded operands for any number of read ports, and raises a stall when a source depends on a load whose data is not yet available. A saturating stall counter is included for performance debug.

## Interface
- DATA_W, 64, operand/result width
- ADDR_W, 5, register index width
- NUM_RD, 2, number of read ports forwarded
- DEPTH, 2, tracked stages after issue (stage 0 = EX, stage 1 = MEM, ...), ≥1
- LOAD_LAT, 2, stages a load occupies before its data is valid (1..DEPTH)
- ZERO_REG, 31, hard-zero register index, never forwarded
- CNT_W, 16, stall counter width

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous, active-low reset
- rd_addr  in  NUM_RD×ADDR_W  source register per read port
- rd_used  in  NUM_RD  port actually read by the issuing instruction
- rf_data  in  NUM_RD×DATA_W  register-file read data per port
- iss_valid  in  1  instruction in decode is valid
- iss_rd  in  ADDR_W  its destination
- iss_wen  in  1  it writes a register
- iss_load  in  1  it is a load
- flush  in  1  kill the decode instruction and stage-0 entry
- stage_data  in  DEPTH×DATA_W  result currently produced by each tracked stage
- fwd_data  out  NUM_RD×DATA_W  operand to execute
- stall  out  1  hold decode/fetch, insert bubble
- stall_cnt  out  CNT_W  saturating count of stall cycles

## Operation
- Table: DEPTH entries {valid, rd, wen, load}; entry k describes instruction in stage k.
- Match for port p at entry k: entry valid & wen & rd == rd_addr[p] & rd_addr[p] != ZERO_REG.
- Priority: lowest k (youngest) match wins; older matches ignored.
- Entry k ready: !load, or k ≥ LOAD_LAT−1.
- Youngest match ready → fwd_data[p] = stage_data[k]; no match → rf_data[p].
- Youngest match not ready and rd_used[p] & iss_valid → stall = 1; fwd_data[p] = rf_data[p] (don't-care).
- stall = OR over ports; zero register and unused ports never stall.
- Advance every clock: entry k ← entry k−1 for k ≥ 1 (no freeze; downstream never stalls).
- Entry 0 ← {iss_valid, iss_rd, iss_wen, iss_load} when !stall & !flush; else bubble (valid=0).
- flush: entry 0 and the incoming issue both become bubbles at the next edge; entries ≥1 shift normally; stall forced 0 during flush.
- stall_cnt increments by 1 each cycle stall=1, saturates at all-ones, never wraps.

## Timing
- fwd_data and stall: combinational from inputs and table, same cycle.
- Table and stall_cnt update on rising clk.
- Reset (asserted async, any time, including mid-stall): all entries invalid, stall_cnt = 0; hence stall = 0, fwd_data = rf_data immediately.
- Instruction issued at cycle t is entry k during cycle t+1+k; leaves table after t+DEPTH.
- Load-use with LOAD_LAT=2: dependent stalls exactly 1 cycle, then forwards from stage 1.
- Simultaneous match in several entries: youngest only; simultaneous stall and flush: flush wins.

## Structure
- Package fwd_pkg: entry struct typedef {valid, rd, wen, load}, ZERO_REG constant default.
- Sub-module fwd_port_sel (one per read port, generate loop): match/priority/ready logic, outputs data and stall_req.
- Top holds table shift register, stall OR, and stall counter.

## Test plan
- Reset mid-operation: table full of loads to x3, stall=1, deassert reset_n → stall=0, stall_cnt=0 asynchronously, fwd_data=rf_data.
- ALU back-to-back: issue add→x5, next reads x5 with stage_data[0]=0x1234 → fwd_data[0]=0x1234, stall=0.
- Priority: x7 in stage 1 (0xAAAA) and stage 0 (0xBBBB) → fwd_data=0xBBBB.
- Load-use: ldur→x2 then add reads x2 → one stall cycle, bubble in entry 0, next cycle fwd_data=stage_data[1]=0xDEAD, stall_cnt=1.
- Zero reg and unused port: load→x31 then read x31, plus load→x4 with rd_used=0 for x4 → no stall, rf_data passed.
- Flush/saturation: flush during load-use stall → stall=0, entry 0 bubble; CNT_W=4 with 20 stall cycles → stall_cnt holds 15.
